fwd_stream_ctrl: RTL and testbench

//  Forwarder-side sequencer for the triple-buffered packet memory. Waits for

---
 rtl/fwd_stream_ctrl.sv | 123 ++++++++++++
 tb/tb_fwd_stream_ctrl.sv | 265 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/fwd_stream_ctrl.sv
// rtl/fwd_stream_ctrl.sv - forwarder-side sequencer: packet buffer reads to AXI-Stream
module fwd_stream_ctrl #(
  parameter int PACKET_BYTE_ADDR_WIDTH = 12,
  parameter int SNOOP_FWD_ADDR_WIDTH   = 9,
  localparam int DW = 2 ** (3 + PACKET_BYTE_ADDR_WIDTH - SNOOP_FWD_ADDR_WIDTH),
  localparam int LW = SNOOP_FWD_ADDR_WIDTH + 1
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic                            ready_for_forwarder,
  input  logic [LW-1:0]                   len_to_forwarder,
  output logic [SNOOP_FWD_ADDR_WIDTH-1:0] forwarder_rd_addr,
  output logic                            forwarder_rd_en,
  input  logic [DW-1:0]                   forwarder_rd_data,
  output logic                            forwarder_done,
  output logic [DW-1:0]                   m_axis_tdata,
  output logic                            m_axis_tvalid,
  input  logic                            m_axis_tready,
  output logic                            m_axis_tlast
);

  localparam logic [LW-1:0] MAX_LEN = LW'(2 ** SNOOP_FWD_ADDR_WIDTH);

  typedef enum logic [1:0] {IDLE, STREAM, DRAIN, DONE} state_t;

  state_t        state;
  logic [LW-1:0] len_q;
  logic [LW-1:0] rd_cnt;
  logic [LW-1:0] beat_cnt;
  logic [LW-1:0] len_m1;
  logic          done_q;

  // Two-entry output buffer fed by the 1-cycle-latency read port.
  logic [DW-1:0] fifo_mem [2];
  logic          head;
  logic          tail;
  logic [1:0]    occ;
  logic          rd_inflight;

  logic          pop;
  logic          issue;
  logic [2:0]    credit_sum;
  logic          last_read;
  logic          last_beat;

  assign len_m1     = len_q - LW'(1);
  assign pop        = m_axis_tvalid & m_axis_tready;
  // Entries held or already promised after this cycle's pop; a read may only
  // be issued while that leaves a free slot for its data next cycle.
  assign credit_sum = {1'b0, occ} + {2'b00, rd_inflight} - {2'b00, pop};
  assign issue      = !rst && (state == STREAM) && (credit_sum < 3'd2);
  assign last_read  = issue && (rd_cnt == len_m1);
  assign last_beat  = pop && (beat_cnt == len_m1);

  assign forwarder_rd_en   = issue;
  assign forwarder_rd_addr = rd_cnt[SNOOP_FWD_ADDR_WIDTH-1:0];
  assign forwarder_done    = done_q;
  assign m_axis_tvalid     = (occ != 2'd0);
  assign m_axis_tdata      = m_axis_tvalid ? fifo_mem[head] : '0;
  assign m_axis_tlast      = m_axis_tvalid && (beat_cnt == len_m1);

  // Packet sequencing FSM with read/beat counters and the done pulse.
  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      len_q    <= '0;
      rd_cnt   <= '0;
      beat_cnt <= '0;
      done_q   <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state)
        IDLE: begin
          if (ready_for_forwarder) begin
            rd_cnt   <= '0;
            beat_cnt <= '0;
            len_q    <= (len_to_forwarder > MAX_LEN) ? MAX_LEN : len_to_forwarder;
            if (len_to_forwarder == '0) begin
              state  <= DONE;
              done_q <= 1'b1;
            end else begin
              state <= STREAM;
            end
          end
        end
        STREAM: begin
          if (issue) rd_cnt <= rd_cnt + LW'(1);
          if (pop) beat_cnt <= beat_cnt + LW'(1);
          if (last_read) state <= DRAIN;
        end
        DRAIN: begin
          if (pop) beat_cnt <= beat_cnt + LW'(1);
          if (last_beat) begin
            state  <= DONE;
            done_q <= 1'b1;
          end
        end
        DONE: state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  // Output buffer: capture read data the cycle after each read, release on handshake.
  always_ff @(posedge clk) begin
    if (rst) begin
      rd_inflight <= 1'b0;
      head        <= 1'b0;
      tail        <= 1'b0;
      occ         <= 2'd0;
      for (int i = 0; i < 2; i++) fifo_mem[i] <= '0;
    end else begin
      rd_inflight <= issue;
      if (rd_inflight) begin
        fifo_mem[tail] <= forwarder_rd_data;
        tail           <= ~tail;
      end
      if (pop) head <= ~head;
      occ <= occ + {1'b0, rd_inflight} - {1'b0, pop};
    end
  end

endmodule

// File: tb/tb_fwd_stream_ctrl.sv
// tb/tb_fwd_stream_ctrl.sv - scoreboard bench for fwd_stream_ctrl
module tb_fwd_stream_ctrl;
  localparam int SFAW   = 9;
  localparam int DW     = 64;
  localparam int LW     = 10;
  localparam int MAXLEN = 512;

  logic            clk = 1'b0;
  logic            rst = 1'b1;
  logic            ready = 1'b0;
  logic [LW-1:0]   len = '0;
  logic [SFAW-1:0] rd_addr;
  logic            rd_en;
  logic [DW-1:0]   rd_data = '0;
  logic            done;
  logic [DW-1:0]   tdata;
  logic            tvalid;
  logic            tready = 1'b0;
  logic            tlast;

  fwd_stream_ctrl dut (
    .clk                 (clk),
    .rst                 (rst),
    .ready_for_forwarder (ready),
    .len_to_forwarder    (len),
    .forwarder_rd_addr   (rd_addr),
    .forwarder_rd_en     (rd_en),
    .forwarder_rd_data   (rd_data),
    .forwarder_done      (done),
    .m_axis_tdata        (tdata),
    .m_axis_tvalid       (tvalid),
    .m_axis_tready       (tready),
    .m_axis_tlast        (tlast)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [DW-1:0] data;
    logic          last;
  } beat_t;

  beat_t       exp_q[$];
  int          n_checks = 0;
  int          n_fail = 0;
  int          exp_addr = 0;
  int          rd_seen = 0;
  int          beats_seen = 0;
  int          done_cnt = 0;
  logic [31:0] pkt_tag = '0;
  logic        stalled_prev = 1'b0;
  logic [DW-1:0] prev_data = '0;

  // Packet memory model: data encodes packet tag and word address, 1-cycle latency.
  always @(posedge clk) begin
    if (rd_en) rd_data <= {pkt_tag, 23'd0, rd_addr};
  end

  // Monitor: read addresses, stall stability, and beat scoreboard.
  always @(negedge clk) begin
    beat_t e;
    if (rst) begin
      stalled_prev = 1'b0;
    end else begin
      if (rd_en) begin
        n_checks++;
        if (rd_addr !== exp_addr[SFAW-1:0]) begin
          n_fail++;
          $display("FAIL rd_addr: got %0d expected %0d", rd_addr, exp_addr);
        end
        exp_addr++;
        rd_seen++;
      end
      if (stalled_prev) begin
        n_checks++;
        if (tvalid !== 1'b1 || tdata !== prev_data) begin
          n_fail++;
          $display("FAIL stall_hold: tvalid=%b tdata=%h expected tvalid=1 tdata=%h", tvalid, tdata, prev_data);
        end
      end
      if (tvalid && tready) begin
        n_checks++;
        if (exp_q.size() == 0) begin
          n_fail++;
          $display("FAIL unexpected_beat: tdata=%h tlast=%b expected no beat", tdata, tlast);
        end else begin
          e = exp_q.pop_front();
          if (tdata !== e.data || tlast !== e.last) begin
            n_fail++;
            $display("FAIL beat: tdata=%h tlast=%b expected tdata=%h tlast=%b", tdata, tlast, e.data, e.last);
          end
        end
        beats_seen++;
      end
      if (done) done_cnt++;
      stalled_prev = tvalid && !tready;
      prev_data = tdata;
    end
  end

  initial begin
    #900000;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1, "watchdog");
  end

  task automatic start_packet(input int l);
    beat_t e;
    int n;
    n = (l > MAXLEN) ? MAXLEN : l;
    pkt_tag = $urandom;
    exp_addr = 0;
    for (int i = 0; i < n; i++) begin
      e.data = {pkt_tag, 32'(i)};
      e.last = (i == n - 1);
      exp_q.push_back(e);
    end
    @(posedge clk); #1;
    ready = 1'b1;
    len = LW'(l);
    @(posedge clk); #1;
    ready = 1'b0;
    len = LW'($urandom);
  endtask

  task automatic run_packet(input int l, input int mode, input string name);
    int n, d0, r0, b0, cyc;
    n = (l > MAXLEN) ? MAXLEN : l;
    d0 = done_cnt; r0 = rd_seen; b0 = beats_seen; cyc = 0;
    tready = (mode == 0);
    start_packet(l);
    while (done_cnt == d0 && cyc < 4 * n + 50) begin
      if (mode == 1) tready = (cyc >= 6 && cyc < 11) ? 1'b0 : (cyc % 2 == 0);
      @(posedge clk); #1;
      cyc++;
    end
    tready = 1'b1;
    repeat (4) @(posedge clk);
    #1;
    n_checks++;
    if (done_cnt - d0 != 1) begin
      n_fail++;
      $display("FAIL %s done_count: got %0d expected 1", name, done_cnt - d0);
    end
    n_checks++;
    if (rd_seen - r0 != n) begin
      n_fail++;
      $display("FAIL %s read_count: got %0d expected %0d", name, rd_seen - r0, n);
    end
    n_checks++;
    if (beats_seen - b0 != n || exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL %s beat_count: got %0d left %0d expected %0d left 0", name, beats_seen - b0, exp_q.size(), n);
    end
  endtask

  task automatic test_reset();
    repeat (3) @(posedge clk);
    #1;
    n_checks++;
    if ({rd_en, tvalid, tlast, done} !== 4'b0 || tdata !== '0 || rd_addr !== '0) begin
      n_fail++;
      $display("FAIL reset_outputs: rd_en=%b tvalid=%b tlast=%b done=%b tdata=%h addr=%0d expected all 0",
               rd_en, tvalid, tlast, done, tdata, rd_addr);
    end
    rst = 1'b0;
  endtask

  task automatic test_len4_timing();
    logic [7:0] exp_rden, exp_tvalid, exp_tlast, exp_done;
    int d0, b0;
    exp_rden   = 8'b0000_1111;
    exp_tvalid = 8'b0011_1100;
    exp_tlast  = 8'b0010_0000;
    exp_done   = 8'b0100_0000;
    d0 = done_cnt; b0 = beats_seen;
    tready = 1'b1;
    start_packet(4);
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      n_checks++;
      if ({rd_en, tvalid, tlast, done} !== {exp_rden[k], exp_tvalid[k], exp_tlast[k], exp_done[k]}) begin
        n_fail++;
        $display("FAIL len4_cycle%0d: rd_en/tvalid/tlast/done=%b expected %b", k + 1,
                 {rd_en, tvalid, tlast, done}, {exp_rden[k], exp_tvalid[k], exp_tlast[k], exp_done[k]});
      end
      @(posedge clk); #1;
    end
    n_checks++;
    if (done_cnt - d0 != 1 || beats_seen - b0 != 4) begin
      n_fail++;
      $display("FAIL len4_totals: done=%0d beats=%0d expected done=1 beats=4", done_cnt - d0, beats_seen - b0);
    end
  endtask

  task automatic test_len0();
    int d0, r0, b0;
    d0 = done_cnt; r0 = rd_seen; b0 = beats_seen;
    tready = 1'b1;
    start_packet(0);
    n_checks++;
    if (done !== 1'b1 || tvalid !== 1'b0) begin
      n_fail++;
      $display("FAIL len0_done_timing: done=%b tvalid=%b expected done=1 tvalid=0", done, tvalid);
    end
    repeat (4) @(posedge clk);
    #1;
    n_checks++;
    if (done_cnt - d0 != 1 || rd_seen != r0 || beats_seen != b0) begin
      n_fail++;
      $display("FAIL len0_totals: done=%0d reads=%0d beats=%0d expected 1 0 0",
               done_cnt - d0, rd_seen - r0, beats_seen - b0);
    end
  endtask

  task automatic test_reset_mid();
    int d0, b0, cyc;
    d0 = done_cnt; b0 = beats_seen; cyc = 0;
    tready = 1'b1;
    start_packet(6);
    while (beats_seen - b0 < 3 && cyc < 50) begin
      @(posedge clk); #1;
      cyc++;
    end
    n_checks++;
    if (beats_seen - b0 < 3) begin
      n_fail++;
      $display("FAIL reset_mid_timeout: beats=%0d expected 3", beats_seen - b0);
    end
    rst = 1'b1;
    @(posedge clk); #1;
    n_checks++;
    if ({rd_en, tvalid, tlast, done} !== 4'b0 || tdata !== '0 || rd_addr !== '0) begin
      n_fail++;
      $display("FAIL reset_mid_outputs: rd_en=%b tvalid=%b tlast=%b done=%b tdata=%h addr=%0d expected all 0",
               rd_en, tvalid, tlast, done, tdata, rd_addr);
    end
    rst = 1'b0;
    exp_q.delete();
    stalled_prev = 1'b0;
    repeat (6) @(posedge clk);
    #1;
    n_checks++;
    if (done_cnt != d0 || tvalid !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_mid_no_done: done pulses=%0d tvalid=%b expected 0 0", done_cnt - d0, tvalid);
    end
  endtask

  initial begin
    test_reset();
    test_len4_timing();
    run_packet(1, 0, "len1");
    test_len0();
    run_packet(8, 1, "stall_len8");
    run_packet(512, 0, "full_len512");
    run_packet(3, 0, "after_full_len3");
    run_packet(600, 1, "clamp_len600");
    test_reset_mid();
    run_packet(5, 1, "after_reset_len5");
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
